// File: rtl/axil_master_param.sv
// AXI4-Lite single-outstanding master: turns a command/response handshake pair
// into AW/W/B or AR/R transactions and counts non-OKAY responses.
module axil_master_param #(
   parameter  int ADDR_W   = 4,
   parameter  int DATA_W   = 32,
   parameter  int ERRCNT_W = 8,
   localparam int STRB_W   = DATA_W / 8
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic [2:0]          AWPROT,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [DATA_W-1:0]   WDATA,
   output logic [STRB_W-1:0]   WSTRB,
   output logic                WVALID,
   input  logic                WREADY,
   input  logic [1:0]          BRESP,
   input  logic                BVALID,
   output logic                BREADY,
   output logic [ADDR_W-1:0]   ARADDR,
   output logic [2:0]          ARPROT,
   output logic                ARVALID,
   input  logic                ARREADY,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP,
   input  logic                RVALID,
   output logic                RREADY,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [STRB_W-1:0]   cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [ERRCNT_W-1:0] err_count
);

   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [STRB_W-1:0]  wstrb_q;
   logic               aw_done, w_done;
   logic               cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, err_hit;

   // All VALID/READY outputs decode registered state only, never the peer's READY/VALID.
   assign cmd_ready = ARESETn && (state == IDLE);
   assign AWVALID   = (state == WR) && !aw_done;
   assign WVALID    = (state == WR) && !w_done;
   assign BREADY    = (state == WR_B);
   assign ARVALID   = (state == RD_A);
   assign RREADY    = (state == RD_R);
   assign rsp_valid = (state == RSP);

   assign AWADDR = addr_q;
   assign ARADDR = addr_q;
   assign WDATA  = wdata_q;
   assign WSTRB  = wstrb_q;
   assign AWPROT = 3'b000;
   assign ARPROT = 3'b000;

   assign cmd_hs  = cmd_valid && cmd_ready;
   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;
   assign b_hs    = BVALID && BREADY;
   assign ar_hs   = ARVALID && ARREADY;
   assign r_hs    = RVALID && RREADY;
   assign err_hit = (b_hs && (BRESP != 2'b00)) || (r_hs && (RRESP != 2'b00));

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_hs) state_nxt = cmd_write ? WR : RD_A;
         WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
         WR_B:    if (b_hs) state_nxt = RSP;
         RD_A:    if (ar_hs) state_nxt = RD_R;
         RD_R:    if (r_hs) state_nxt = RSP;
         RSP:     if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
         err_count <= '0;
      end else begin
         if (cmd_hs) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         // Write responses leave rsp_rdata holding the last read data.
         if (b_hs) begin
            rsp_resp  <= BRESP;
            rsp_write <= 1'b1;
         end
         if (r_hs) begin
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_write <= 1'b0;
         end
         if (err_hit && (err_count != {ERRCNT_W{1'b1}}))
            err_count <= err_count + ERRCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_axil_master_param.sv
// Self-checking bench for axil_master_param: scripted AXI-Lite slave plus a
// scoreboard of expected responses popped at each rsp handshake.
module tb_axil_master_param;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [3:0]  AWADDR, ARADDR;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA, cmd_wdata, rsp_rdata;
   logic [3:0]  WSTRB, cmd_wstrb, cmd_addr;
   logic [1:0]  BRESP, RRESP, rsp_resp, err_count;
   logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_write;

   typedef struct {logic wr; logic [31:0] rdata; logic [1:0] resp;} exp_t;
   exp_t        sb[$];
   int          tests = 0, fails = 0;
   logic [31:0] last_rdata = '0;
   logic [1:0]  err_exp = '0;

   axil_master_param #(.ADDR_W(4), .DATA_W(32), .ERRCNT_W(2)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full transaction; slave delays count cycles from the first cycle after accept.
   task automatic run_txn(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int aw_dly, input int w_dly,
                          input int rsp_dly, input int hold, input logic [1:0] resp,
                          input logic [31:0] rd);
      exp_t e;
      int viol = 0, awn = 0, wn = 0, arn = 0, hv = 0;
      logic aw_d = 0, w_d = 0, ar_d = 0, aw_p, w_p, ar_p, b_p, r_p;
      logic fw; logic [31:0] frd; logic [1:0] frs;
      e.wr = wr; e.resp = resp; e.rdata = wr ? last_rdata : rd;
      if (!wr) last_rdata = rd;
      if (resp != 2'b00 && err_exp != 2'b11) err_exp++;
      sb.push_back(e);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge ACLK); #1;
      cmd_valid = 0;
      for (int c = 0; c < 200 && !rsp_valid; c++) begin
         AWREADY = wr && !aw_d && c >= aw_dly;
         WREADY  = wr && !w_d && c >= w_dly;
         ARREADY = !wr && !ar_d && c >= aw_dly;
         if (wr && aw_d && w_d && c >= rsp_dly) begin BVALID = 1; BRESP = resp; end
         if (!wr && ar_d && c >= rsp_dly) begin RVALID = 1; RDATA = rd; RRESP = resp; end
         if (wr && !aw_d && !AWVALID) viol++;
         if (wr && !w_d && !WVALID) viol++;
         if (!wr && !ar_d && !ARVALID) viol++;
         if (!wr && (AWVALID || WVALID)) viol++;
         if (aw_d && AWVALID) viol++;
         if (w_d && WVALID) viol++;
         if (AWVALID && AWADDR !== a) viol++;
         if (WVALID && (WDATA !== wd || WSTRB !== ws)) viol++;
         if (ARVALID && ARADDR !== a) viol++;
         if (BREADY && !(aw_d && w_d)) viol++;
         if (!wr && ar_d && RREADY !== 1'b1) viol++;
         if (cmd_ready) viol++;
         aw_p = AWVALID && AWREADY; w_p = WVALID && WREADY; ar_p = ARVALID && ARREADY;
         b_p = BVALID && BREADY;   r_p = RVALID && RREADY;
         awn += int'(aw_p); wn += int'(w_p); arn += int'(ar_p);
         @(posedge ACLK); #1;
         if (aw_p) aw_d = 1;
         if (w_p)  w_d = 1;
         if (ar_p) ar_d = 1;
         if (b_p)  BVALID = 0;
         if (r_p)  RVALID = 0;
      end
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      chk("rsp_valid_seen", rsp_valid, 1);
      chk("proto", viol, 0);
      if (wr) begin chk("aw_hs_cnt", awn, 1); chk("w_hs_cnt", wn, 1); end
      else chk("ar_hs_cnt", arn, 1);
      fw = rsp_write; frd = rsp_rdata; frs = rsp_resp;
      for (int h = 0; h < hold; h++) begin
         @(posedge ACLK); #1;
         if (!rsp_valid || cmd_ready || rsp_write !== fw || rsp_rdata !== frd || rsp_resp !== frs) hv++;
      end
      chk("rsp_hold", hv, 0);
      chk("sb_depth", sb.size(), 1);
      e = sb.pop_front();
      chk("rsp_write", rsp_write, e.wr);
      chk("rsp_resp", rsp_resp, e.resp);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("err_count", err_count, err_exp);
      rsp_ready = 1;
      chk("cmd_ready_rsp_cycle", cmd_ready, 0);
      @(posedge ACLK); #1;
      rsp_ready = 0;
      chk("rsp_valid_dropped", rsp_valid, 0);
   endtask

   initial begin
      ARESETn = 0; AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      BRESP = 0; RRESP = 0; RDATA = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
      cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      ARESETn = 1;
      @(posedge ACLK); #1;
      chk("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
      chk("rst_prot", {AWPROT, ARPROT}, 0);
      chk("rst_err", err_count, 0);
      chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);

      run_txn(1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0);
      run_txn(1, 4'hC, 32'hA5A50001, 4'h3, 3, 0, 0, 0, 2'b00, 32'h0);
      run_txn(0, 4'h8, 32'h0, 4'h0, 0, 0, 6, 0, 2'b00, 32'h12345678);
      run_txn(0, 4'h4, 32'h0, 4'h0, 1, 0, 2, 4, 2'b00, 32'hCAFEF00D);
      run_txn(1, 4'h0, 32'h0BADF00D, 4'h1, 0, 2, 1, 0, 2'b00, 32'h0);

      // Stray responses while idle must be ignored.
      BVALID = 1; BRESP = 2'b10; RVALID = 1; RRESP = 2'b11; RDATA = 32'hFFFF0000;
      repeat (2) @(posedge ACLK);
      #1;
      BVALID = 0; RVALID = 0;
      chk("stray_err", err_count, err_exp);
      chk("stray_idle", {cmd_ready, rsp_valid}, 2'b10);
      chk("stray_rdata", rsp_rdata, last_rdata);

      for (int i = 0; i < 5; i++)
         run_txn(1, 4'h2, 32'h100 + i, 4'hF, i % 2, 0, i, 0, 2'b10, 32'h0);

      // Abandon a write mid-flight with AWVALID up.
      cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h6; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
      @(posedge ACLK); #1;
      cmd_valid = 0;
      @(posedge ACLK); #1;
      chk("pre_rst_awvalid", AWVALID, 1);
      #2 ARESETn = 0;
      #1;
      chk("arst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
      chk("arst_cmd_ready", cmd_ready, 0);
      chk("arst_err", err_count, 0);
      sb.delete(); err_exp = 0; last_rdata = 0;
      @(posedge ACLK); @(posedge ACLK);
      #3 ARESETn = 1;
      @(posedge ACLK); #1;
      chk("post_rst_idle", {cmd_ready, rsp_valid}, 2'b10);
      run_txn(0, 4'h8, 32'h0, 4'h0, 2, 0, 4, 1, 2'b00, 32'h87654321);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axil_master_param.md
AXIL_MASTER_PARAM -- requirements
Module: axil_master_param

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, AXI address width in bits (min 2).
REQ-002 SHALL provide parameter DATA_W, default 32, AXI data width; legal values 32 or 64.
REQ-003 SHALL derive STRB_W = DATA_W/8 as a localparam.
REQ-004 SHALL provide parameter ERRCNT_W, default 8, width of the error counter.
REQ-005 SHALL have port ACLK, input, 1, clock; all logic is rising-edge.
REQ-006 SHALL have port ARESETn, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have AW ports: AWADDR out ADDR_W; AWPROT out 3, tied 3'b000; AWVALID out 1; AWREADY in 1.
REQ-008 SHALL have W ports: WDATA out DATA_W; WSTRB out STRB_W; WVALID out 1; WREADY in 1.
REQ-009 SHALL have B ports: BRESP in 2; BVALID in 1; BREADY out 1.
REQ-010 SHALL have AR ports: ARADDR out ADDR_W; ARPROT out 3, tied 3'b000; ARVALID out 1; ARREADY in 1.
REQ-011 SHALL have R ports: RDATA in DATA_W; RRESP in 2; RVALID in 1; RREADY out 1.
REQ-012 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1; cmd_addr in ADDR_W; cmd_wdata in DATA_W; cmd_wstrb in STRB_W.
REQ-013 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_write out 1; rsp_rdata out DATA_W; rsp_resp out 2.
REQ-014 SHALL have port err_count, out, ERRCNT_W, saturating count of non-OKAY responses.

Function
REQ-015 SHALL implement one FSM with states IDLE, WR, WR_B, RD_A, RD_R, RSP; one transaction outstanding at most.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-017 SHALL register cmd_addr/cmd_wdata/cmd_wstrb/cmd_write on acceptance; AXI outputs come only from these registers.
REQ-018 SHALL, on write accept, go IDLE->WR and assert AWVALID and WVALID together the next cycle.
REQ-019 SHALL track AW and W done flags separately; each VALID deasserts the cycle after its own handshake, independent of the other channel.
REQ-020 SHALL accept simultaneous AW and W handshakes in one cycle, and handshakes in either order.
REQ-021 SHALL hold each VALID and its payload stable until handshake; no VALID may depend combinationally on READY.
REQ-022 SHALL go WR->WR_B once both flags are set; BREADY=1 only in WR_B.
REQ-023 SHALL, on BVALID&&BREADY, capture BRESP into rsp_resp, set rsp_write=1, and go to RSP.
REQ-024 SHALL, on read accept, go IDLE->RD_A and assert ARVALID the next cycle until ARREADY, then go to RD_R.
REQ-025 SHALL assert RREADY=1 only in RD_R; on RVALID capture RDATA/RRESP, set rsp_write=0, and go to RSP.
REQ-026 SHALL hold rsp_valid=1 in RSP until rsp_ready, then return to IDLE; rsp_* stay stable while rsp_valid=1.
REQ-027 SHALL accept no new command in the rsp_ready cycle; IDLE is reached one cycle later, giving a minimum of 4 cycles accept-to-accept.
REQ-028 SHALL keep rsp_rdata unchanged on write responses.
REQ-029 SHALL increment err_count by 1 when a captured response is not 2'b00, saturating at all-ones without wrap.
REQ-030 SHALL ignore BVALID and RVALID outside WR_B and RD_R; such stray pulses change no state.

Reset
REQ-031 SHALL, on ARESETn low, force IDLE immediately, with AWVALID=WVALID=ARVALID=BREADY=RREADY=rsp_valid=0, cmd_ready=0 while reset is held, and all data/addr/strb/resp registers and err_count=0.
REQ-032 SHALL, on reset mid-transaction, abandon the transaction without generating a response; cmd_ready=1 from the first clock after deassertion.

Verification
REQ-033 Write, AW/W ready immediately: addr=0x4, wdata=0xDEADBEEF, wstrb=0xF, BRESP=0 -> one AW and one W handshake, rsp_valid with rsp_write=1, rsp_resp=0, err_count=0.
REQ-034 Skewed write: WREADY 3 cycles before AWREADY -> WVALID low after its handshake, AWVALID held with AWADDR stable, BREADY asserted only after the AW handshake.
REQ-035 Read: addr=0x8, RDATA=0x12345678, RRESP=0, RVALID delayed 5 cycles -> rsp_rdata=0x12345678, rsp_write=0; RREADY high throughout the wait.
REQ-036 Error saturation, ERRCNT_W=2: five writes with BRESP=2'b10 -> err_count sequence 1,2,3,3,3.
REQ-037 Backpressure: rsp_ready held low 4 cycles -> rsp_* stable and cmd_ready=0 throughout; the next command is accepted the cycle after IDLE is re-entered.
REQ-038 Reset during WR with AWVALID high -> all VALIDs 0 asynchronously, no rsp_valid, and a subsequent read completes normally.
